pipeline_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage RV64 pipeline. Detects load-use hazards in ID, converts a taken branch resolved in EX into IF/ID and ID/EX flushes, and freezes the whole pipeline while the data memory holds off a request. A watchdog flags a data-memory timeout, and saturating performance counters record stall and flush cycles. Its outputs drive the PC enable and the stall and flush inputs of every pipeline register.

---
 rtl/pipeline_hazard_ctrl_if.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipeline_hazard_ctrl.
// The datapath side (master) supplies hazard sources; the controller side (slave) returns stall/flush controls.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic             uses_rs2_d;
    logic [4:0]       rd_e;
    logic             mem_read_e;
    logic             branch_taken_e;
    logic             mem_req_m;
    logic             mem_ready_m;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic             freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output rs1_d, rs2_d, uses_rs2_d, rd_e, mem_read_e, branch_taken_e, mem_req_m, mem_ready_m,
        input  stall_f, stall_d, flush_d, flush_e, freeze, mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  rs1_d, rs2_d, uses_rs2_d, rd_e, mem_read_e, branch_taken_e, mem_req_m, mem_ready_m,
        output stall_f, stall_d, flush_d, flush_e, freeze, mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory freeze with timeout watchdog, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int unsigned         WCNT_W    = 16;
    localparam logic [WCNT_W-1:0]   WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              timeout;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic mem_hold;
    logic load_use;
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic flush_e;
    logic freeze;

    assign mem_hold = bus.mem_req_m & ~bus.mem_ready_m;
    assign load_use = bus.mem_read_e & (bus.rd_e != 5'd0) &
                      ((bus.rd_e == bus.rs1_d) | (bus.uses_rs2_d & (bus.rd_e == bus.rs2_d)));

    // Priority: ERROR > memory hold > taken branch > load-use; everything quiet during reset.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        freeze  = 1'b0;
        if (!rst) begin
            if ((state == ERROR) || mem_hold) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                freeze  = 1'b1;
            end else if (bus.branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wcnt      <= '0;
            timeout   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_hold) begin
                        state <= MEM_WAIT;
                        wcnt  <= WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_hold) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WCNT_LAST) begin
                        state   <= ERROR;
                        timeout <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase

            // Counters saturate rather than wrap.
            if (stall_f && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_d && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_f      = stall_f;
    assign bus.stall_d      = stall_d;
    assign bus.flush_d      = flush_d;
    assign bus.flush_e      = flush_e;
    assign bus.freeze       = freeze;
    assign bus.mem_timeout  = timeout;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model; a second instance with 2-bit counters checks saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO     = 4;
    localparam longint      MAX32  = 64'd4294967295;
    localparam int          MAX2   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) bus  ();
    pipeline_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut     (.clk(clk), .rst(rst), .bus(bus));
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus2));

    assign bus2.rs1_d          = bus.rs1_d;
    assign bus2.rs2_d          = bus.rs2_d;
    assign bus2.uses_rs2_d     = bus.uses_rs2_d;
    assign bus2.rd_e           = bus.rd_e;
    assign bus2.mem_read_e     = bus.mem_read_e;
    assign bus2.branch_taken_e = bus.branch_taken_e;
    assign bus2.mem_req_m      = bus.mem_req_m;
    assign bus2.mem_ready_m    = bus.mem_ready_m;

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Behavioural model: error flag, length of the current run of held cycles, counters.
    bit     m_err;
    int     m_wait;
    bit     m_to;
    longint m_stall, m_flush;
    int     m_stall2, m_flush2;
    bit     e_sf, e_sd, e_fd, e_fe, e_fz;

    task automatic model_comb();
        bit hold, lu;
        hold = bus.mem_req_m && !bus.mem_ready_m;
        lu   = bus.mem_read_e && (bus.rd_e != 0) &&
               ((bus.rd_e == bus.rs1_d) || (bus.uses_rs2_d && (bus.rd_e == bus.rs2_d)));
        {e_sf, e_sd, e_fd, e_fe, e_fz} = 5'b0;
        if (rst) ;
        else if (m_err || hold) {e_sf, e_sd, e_fz} = 3'b111;
        else if (bus.branch_taken_e) {e_fd, e_fe} = 2'b11;
        else if (lu) {e_sf, e_sd, e_fe} = 3'b111;
    endtask

    task automatic tick();
        bit hold;
        @(posedge clk);
        model_comb();
        hold = bus.mem_req_m && !bus.mem_ready_m;
        if (rst) begin
            m_err = 0; m_wait = 0; m_to = 0;
            m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
        end else begin
            if (!m_err) begin
                if (!hold) m_wait = 0;
                else if (m_wait + 1 == TO) begin m_err = 1; m_to = 1; end
                else m_wait++;
            end
            if (e_sf) begin
                if (m_stall < MAX32) m_stall++;
                if (m_stall2 < MAX2) m_stall2++;
            end
            if (e_fd) begin
                if (m_flush < MAX32) m_flush++;
                if (m_flush2 < MAX2) m_flush2++;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.rs1_d = 0; bus.rs2_d = 0; bus.uses_rs2_d = 0; bus.rd_e = 0;
        bus.mem_read_e = 0; bus.branch_taken_e = 0; bus.mem_req_m = 0; bus.mem_ready_m = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        bus.mem_req_m = 1; bus.branch_taken_e = 1; bus.mem_read_e = 1; bus.rd_e = 3; bus.rs1_d = 3;
        tick();
        @(negedge clk);
        checks++;
        if ({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze});
        else passes++;
        tick();
        clear_inputs();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({bus.mem_timeout, bus.stall_cycles, bus.flush_events, bus.freeze} !== 66'b0)
            $display("FAIL reset_state: timeout=%b stall=%0d flush=%0d freeze=%b want all 0",
                     bus.mem_timeout, bus.stall_cycles, bus.flush_events, bus.freeze);
        else passes++;
    endtask

    task automatic test_load_use();
        do_reset();
        bus.mem_read_e = 1; bus.rd_e = 5; bus.rs1_d = 5; bus.rs2_d = 9;
        @(negedge clk);
        checks++;
        if ({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze} !== 5'b11010)
            $display("FAIL load_use_bubble: got %b want 11010", {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze});
        else passes++;
        tick();
        bus.mem_read_e = 0; bus.rd_e = 2;
        @(negedge clk);
        checks++;
        if ({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze} !== 5'b0)
            $display("FAIL load_use_release: got %b want 00000", {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze});
        else passes++;
        checks++;
        if (bus.stall_cycles !== 32'd1) $display("FAIL load_use_count: got %0d want 1", bus.stall_cycles);
        else passes++;
    endtask

    task automatic test_gating();
        do_reset();
        bus.mem_read_e = 1; bus.rd_e = 0; bus.rs1_d = 0;
        @(negedge clk);
        checks++;
        if (bus.stall_f !== 1'b0) $display("FAIL x0_gating: stall_f got %b want 0", bus.stall_f);
        else passes++;
        bus.rd_e = 7; bus.rs1_d = 3; bus.rs2_d = 7; bus.uses_rs2_d = 0;
        @(negedge clk);
        checks++;
        if (bus.stall_f !== 1'b0) $display("FAIL rs2_unused_gating: stall_f got %b want 0", bus.stall_f);
        else passes++;
        bus.uses_rs2_d = 1;
        @(negedge clk);
        checks++;
        if ({bus.stall_f, bus.flush_e} !== 2'b11) $display("FAIL rs2_used_hazard: got %b want 11", {bus.stall_f, bus.flush_e});
        else passes++;
        tick();
    endtask

    task automatic test_branch_load_use();
        do_reset();
        bus.mem_read_e = 1; bus.rd_e = 4; bus.rs1_d = 4; bus.branch_taken_e = 1;
        @(negedge clk);
        checks++;
        if ({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze} !== 5'b00110)
            $display("FAIL branch_over_lu: got %b want 00110", {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze});
        else passes++;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus.flush_events, bus.stall_cycles} !== {32'd1, 32'd0})
            $display("FAIL branch_counts: flush=%0d stall=%0d want 1 0", bus.flush_events, bus.stall_cycles);
        else passes++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.mem_req_m = 1; bus.mem_ready_m = 0; bus.branch_taken_e = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.freeze, bus.stall_f, bus.flush_d, bus.flush_e} !== 4'b1100)
                $display("FAIL mem_wait_hold[%0d]: got %b want 1100", i, {bus.freeze, bus.stall_f, bus.flush_d, bus.flush_e});
            else passes++;
            tick();
        end
        bus.mem_ready_m = 1;
        @(negedge clk);
        checks++;
        if ({bus.freeze, bus.stall_f, bus.flush_d, bus.flush_e} !== 4'b0011)
            $display("FAIL mem_ready_release: got %b want 0011", {bus.freeze, bus.stall_f, bus.flush_d, bus.flush_e});
        else passes++;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus.freeze, bus.stall_cycles, bus.flush_events} !== {1'b0, 32'd3, 32'd1})
            $display("FAIL mem_wait_counts: freeze=%b stall=%0d flush=%0d want 0 3 1", bus.freeze, bus.stall_cycles, bus.flush_events);
        else passes++;
        // A second full-length wait must not time out: the wait count restarted.
        bus.mem_req_m = 1;
        repeat (3) tick();
        bus.mem_ready_m = 1;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus.mem_timeout, bus.freeze} !== 2'b00)
            $display("FAIL mem_wait_restart: timeout=%b freeze=%b want 0 0", bus.mem_timeout, bus.freeze);
        else passes++;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.mem_req_m = 1; bus.mem_ready_m = 0;
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_timeout, bus.freeze} !== 2'b01)
                $display("FAIL timeout_early[%0d]: got %b want 01", i, {bus.mem_timeout, bus.freeze});
            else passes++;
            tick();
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_timeout, bus.freeze} !== 2'b11)
            $display("FAIL timeout_rise: got %b want 11", {bus.mem_timeout, bus.freeze});
        else passes++;
        bus.mem_ready_m = 1; bus.branch_taken_e = 1;
        tick();
        @(negedge clk);
        checks++;
        if ({bus.mem_timeout, bus.freeze, bus.stall_f, bus.flush_d} !== 4'b1110)
            $display("FAIL error_sticky: got %b want 1110", {bus.mem_timeout, bus.freeze, bus.stall_f, bus.flush_d});
        else passes++;
        rst = 1;
        @(negedge clk);
        checks++;
        if ({bus.freeze, bus.stall_f, bus.flush_d, bus.flush_e} !== 4'b0)
            $display("FAIL error_rst_quiet: got %b want 0000", {bus.freeze, bus.stall_f, bus.flush_d, bus.flush_e});
        else passes++;
        tick();
        rst = 0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus.mem_timeout, bus.freeze, bus.stall_cycles, bus.flush_events} !== 66'b0)
            $display("FAIL error_cleared: timeout=%b freeze=%b stall=%0d flush=%0d want all 0",
                     bus.mem_timeout, bus.freeze, bus.stall_cycles, bus.flush_events);
        else passes++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.mem_req_m = 1;
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        bus.mem_req_m = 0;
        @(negedge clk);
        checks++;
        if ({bus.freeze, bus.stall_cycles, bus.flush_events} !== 65'b0)
            $display("FAIL mid_wait_reset: freeze=%b stall=%0d flush=%0d want 0 0 0", bus.freeze, bus.stall_cycles, bus.flush_events);
        else passes++;
        bus.mem_req_m = 1;
        repeat (TO - 1) tick();
        @(negedge clk);
        checks++;
        if ({bus.mem_timeout, bus.freeze} !== 2'b01)
            $display("FAIL mid_wait_recount: got %b want 01", {bus.mem_timeout, bus.freeze});
        else passes++;
        bus.mem_ready_m = 1;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.mem_read_e = 1; bus.rd_e = 6; bus.rs1_d = 6;
        repeat (5) tick();
        bus.mem_read_e = 0; bus.branch_taken_e = 1;
        repeat (5) tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({bus2.stall_cycles, bus2.flush_events} !== 4'b1111)
            $display("FAIL sat_cnt2: stall=%0d flush=%0d want 3 3", bus2.stall_cycles, bus2.flush_events);
        else passes++;
        checks++;
        if ({bus.stall_cycles, bus.flush_events} !== {32'd5, 32'd5})
            $display("FAIL sat_cnt32: stall=%0d flush=%0d want 5 5", bus.stall_cycles, bus.flush_events);
        else passes++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst                = ($urandom_range(0, 39) == 0);
            bus.rs1_d          = 5'($urandom_range(0, 3));
            bus.rs2_d          = 5'($urandom_range(0, 3));
            bus.rd_e           = 5'($urandom_range(0, 3));
            bus.uses_rs2_d     = 1'($urandom);
            bus.mem_read_e     = 1'($urandom);
            bus.branch_taken_e = ($urandom_range(0, 3) == 0);
            bus.mem_req_m      = 1'($urandom);
            bus.mem_ready_m    = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            model_comb();
            checks++;
            if ({bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze, bus.mem_timeout} !==
                {e_sf, e_sd, e_fd, e_fe, e_fz, m_to})
                $display("FAIL rand_ctrl[%0d]: got %b want %b", c,
                         {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.freeze, bus.mem_timeout},
                         {e_sf, e_sd, e_fd, e_fe, e_fz, m_to});
            else passes++;
            checks++;
            if ({bus.stall_cycles, bus.flush_events, bus2.stall_cycles, bus2.flush_events} !==
                {32'(m_stall), 32'(m_flush), 2'(m_stall2), 2'(m_flush2)})
                $display("FAIL rand_cnt[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", c,
                         bus.stall_cycles, bus.flush_events, bus2.stall_cycles, bus2.flush_events,
                         m_stall, m_flush, m_stall2, m_flush2);
            else passes++;
            tick();
        end
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        m_err = 0; m_wait = 0; m_to = 0;
        m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
        #1;
        test_reset();
        test_load_use();
        test_gating();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
